wb_gpio_irq: RTL

WB_GPIO_IRQ -- requirements
Module: wb_gpio_irq

---
 rtl/wb_gpio_pkg.sv | 28 ++
 rtl/gpio_sync_edge.sv | 54 +++++
 rtl/wb_gpio_irq.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/wb_gpio_pkg.sv
// Shared register map, counter width and helpers for the Wishbone GPIO block.
package wb_gpio_pkg;

   localparam int unsigned CYCLE_W = 32;

   localparam logic [31:0] OFF_DATA  = 32'h00;
   localparam logic [31:0] OFF_DIR   = 32'h04;
   localparam logic [31:0] OFF_CYCLE = 32'h08;
   localparam logic [31:0] OFF_IEN   = 32'h0C;
   localparam logic [31:0] OFF_STAT  = 32'h10;
   localparam logic [31:0] OFF_POL   = 32'h14;

   // DONE sits at the top word of the decoded window: all ones with [1:0] cleared.
   function automatic logic [31:0] doneOffset(input int unsigned msk);
      logic [31:0] ones;
      ones = (msk >= 32) ? 32'hFFFF_FFFF : ((32'h1 << msk) - 32'h1);
      return ones & ~32'h3;
   endfunction

   function automatic logic [31:0] laneMask(input logic [3:0] sel);
      logic [31:0] m;
      for (int b = 0; b < 4; b++) begin
         m[8*b +: 8] = {8{sel[b]}};
      end
      return m;
   endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-bit input synchroniser with previous-sample and polarity edge detect.
// Edge detection is only built when WB_GPIO_IRQ_EN is defined.
module gpio_sync_edge
   import wb_gpio_pkg::*;
#(
   parameter int GW   = 8,
   parameter int SYNC = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [GW-1:0] gpio_i,
`ifdef WB_GPIO_IRQ_EN
   input  logic [GW-1:0] pol_i,
   output logic [GW-1:0] edge_o,
`endif
   output logic [GW-1:0] sync_o
);

   logic [SYNC-1:0][GW-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC-2:0], gpio_i};
      end
   end

   assign sync_o = sync_q[SYNC-1];

`ifdef WB_GPIO_IRQ_EN
   logic [GW-1:0] prev_q;
   logic [2:0]    armCnt_q;
   logic          armed;

   // The chain refills from zero after reset; hold off until it and prev_q have settled.
   assign armed = (armCnt_q == 3'(SYNC + 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_q   <= '0;
         armCnt_q <= '0;
      end else begin
         prev_q <= sync_o;
         if (!armed) begin
            armCnt_q <= armCnt_q + 3'd1;
         end
      end
   end

   assign edge_o = armed ? ((~pol_i & sync_o & ~prev_q) | (pol_i & ~sync_o & prev_q)) : '0;
`endif

endmodule

// File: rtl/wb_gpio_irq.sv
// Wishbone GPIO with cycle counter and optional edge interrupts.
// Define WB_GPIO_IRQ_EN to build the IEN/STAT/POL registers and irq.
module wb_gpio_irq
   import wb_gpio_pkg::*;
#(
   parameter int MSK  = 24,
   parameter int GW   = 8,
   parameter int AW   = 32,
   parameter int DW   = 32,
   parameter int SYNC = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [GW-1:0]   gpio_i,
   output logic [GW-1:0]   gpio_o,
   output logic [GW-1:0]   gpio_oe,
   output logic            irq,
   output logic            done,
   input  logic [AW-1:0]   i_wb_adr,
   input  logic [DW/8-1:0] i_wb_sel,
   input  logic            i_wb_we,
   input  logic [DW-1:0]   i_wb_dat,
   output logic [DW-1:0]   o_wb_dat,
   input  logic            i_wb_cyc,
   input  logic            i_wb_stb,
   output logic            o_wb_ack,
   output logic            o_wb_err
);

   localparam logic [MSK-1:0] DONE_OFF = MSK'(doneOffset(MSK));

   logic [GW-1:0]      data_q, data_d;
   logic [GW-1:0]      dir_q, dir_d;
   logic [CYCLE_W-1:0] cycle_q, cycle_d;
   logic               ack_q, ack_d;
   logic               err_q, err_d;
   logic               done_q, done_d;
   logic [DW-1:0]      dat_q, dat_d;

   logic [MSK-1:0] offset;
   logic           req, hit, wrReq;
   logic           isData, isDir, isCycle, isIen, isStat, isPol, isDone;
   logic [GW-1:0]  wrMask, wrData, syncIn;
   logic [DW-1:0]  rdData;
   logic           unusedBits;

   assign offset  = i_wb_adr[MSK-1:0];
   assign req     = i_wb_cyc & i_wb_stb & ~ack_q & ~err_q;
   assign isData  = (offset == MSK'(OFF_DATA));
   assign isDir   = (offset == MSK'(OFF_DIR));
   assign isCycle = (offset == MSK'(OFF_CYCLE));
   assign isIen   = (offset == MSK'(OFF_IEN));
   assign isStat  = (offset == MSK'(OFF_STAT));
   assign isPol   = (offset == MSK'(OFF_POL));
   assign isDone  = (offset == DONE_OFF);
   assign hit     = isData | isDir | isCycle | isIen | isStat | isPol | isDone;
   assign wrReq   = req & i_wb_we & hit;
   assign wrMask  = GW'(laneMask(i_wb_sel));
   assign wrData  = i_wb_dat[GW-1:0];

   // Address bits above the window and data bits above GW are ignored by design.
   assign unusedBits = ^{i_wb_adr, i_wb_dat};

`ifdef WB_GPIO_IRQ_EN
   logic [GW-1:0] ien_q, ien_d;
   logic [GW-1:0] stat_q, stat_d;
   logic [GW-1:0] pol_q, pol_d;
   logic [GW-1:0] edges, statClr;

   gpio_sync_edge #(.GW(GW), .SYNC(SYNC)) uSyncEdge (
      .clk    (clk),
      .rst_n  (rst_n),
      .gpio_i (gpio_i),
      .pol_i  (pol_q),
      .edge_o (edges),
      .sync_o (syncIn)
   );

   assign statClr = (wrReq && isStat) ? (wrData & wrMask) : '0;

   // A fresh edge wins over a simultaneous write-one-to-clear.
   always_comb begin
      ien_d  = ien_q;
      pol_d  = pol_q;
      stat_d = (stat_q & ~statClr) | edges;
      if (wrReq && isIen) ien_d = (ien_q & ~wrMask) | (wrData & wrMask);
      if (wrReq && isPol) pol_d = (pol_q & ~wrMask) | (wrData & wrMask);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ien_q  <= '0;
         stat_q <= '0;
         pol_q  <= '0;
      end else begin
         ien_q  <= ien_d;
         stat_q <= stat_d;
         pol_q  <= pol_d;
      end
   end

   assign irq = |(stat_q & ien_q);
`else
   gpio_sync_edge #(.GW(GW), .SYNC(SYNC)) uSyncEdge (
      .clk    (clk),
      .rst_n  (rst_n),
      .gpio_i (gpio_i),
      .sync_o (syncIn)
   );

   assign irq = 1'b0;
`endif

   // CYCLE is the one register read back at full width.
   always_comb begin
      rdData = '0;
      if (isData)       rdData = DW'(syncIn);
      else if (isDir)   rdData = DW'(dir_q);
      else if (isCycle) rdData = DW'(cycle_q);
`ifdef WB_GPIO_IRQ_EN
      else if (isIen)   rdData = DW'(ien_q);
      else if (isStat)  rdData = DW'(stat_q);
      else if (isPol)   rdData = DW'(pol_q);
`endif
   end

   always_comb begin
      data_d  = data_q;
      dir_d   = dir_q;
      cycle_d = cycle_q + 1'b1;
      ack_d   = req & hit;
      err_d   = req & ~hit;
      done_d  = wrReq & isDone;
      dat_d   = '0;
      if (wrReq && isData) data_d = (data_q & ~wrMask) | (wrData & wrMask);
      if (wrReq && isDir)  dir_d  = (dir_q & ~wrMask) | (wrData & wrMask);
      if (req && hit && !i_wb_we) dat_d = rdData;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         dir_q   <= '0;
         cycle_q <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         dat_q   <= '0;
      end else begin
         data_q  <= data_d;
         dir_q   <= dir_d;
         cycle_q <= cycle_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         done_q  <= done_d;
         dat_q   <= dat_d;
      end
   end

   assign gpio_o   = data_q;
   assign gpio_oe  = dir_q;
   assign done     = done_q;
   assign o_wb_ack = ack_q;
   assign o_wb_err = err_q;
   assign o_wb_dat = dat_q;

endmodule
